// File: rtl/mc_alu_if.sv
// rtl/mc_alu_if.sv - request/result handshake bundle for the multi-cycle ALU
interface mc_alu_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_err
    );
endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: pipelined-latency MUL, iterative restoring DIV, one op in flight
module mc_alu #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mc_alu_if.slave      bus
);
    localparam int SH_W    = $clog2(DATA_W);
    localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MUL = 4'd0;
    localparam logic [3:0] OP_DIV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, OUT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  rem_q;
    logic [TAG_W-1:0]   tag_q;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_result_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               out_err_q;

    logic               in_ready;
    logic               accept;
    logic [DATA_W-1:0]  imm_result;
    logic               imm_err;
    logic [DATA_W:0]    div_shift;
    logic [DATA_W:0]    div_diff;
    logic               div_ge;
    logic [DATA_W-1:0]  div_rem_n;
    logic [DATA_W-1:0]  div_quo_n;

    assign in_ready       = rst_n && ((state == IDLE) || (state == OUT && bus.out_ready));
    assign accept         = bus.in_valid && in_ready;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_err    = out_err_q;

    // Results that complete in the accept cycle; DIV here only ever sees a zero divisor.
    always_comb begin
        imm_result = '0;
        imm_err    = 1'b0;
        case (bus.in_op)
            OP_MUL: imm_result = bus.in_a * bus.in_b;
            OP_DIV: begin
                imm_result = '1;
                imm_err    = 1'b1;
            end
            OP_ADD: imm_result = bus.in_a + bus.in_b;
            OP_SUB: imm_result = bus.in_a - bus.in_b;
            OP_SLL: imm_result = bus.in_a << bus.in_b[SH_W-1:0];
            OP_SRL: imm_result = bus.in_a >> bus.in_b[SH_W-1:0];
            OP_SLT: imm_result = {{(DATA_W-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_AND: imm_result = bus.in_a & bus.in_b;
            OP_OR:  imm_result = bus.in_a | bus.in_b;
            OP_XOR: imm_result = bus.in_a ^ bus.in_b;
            default: imm_err   = 1'b1;
        endcase
    end

    // One restoring step: a_q doubles as the dividend/quotient shift register.
    always_comb begin
        div_shift = {rem_q, a_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_rem_n = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
        div_quo_n = {a_q[DATA_W-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            tag_q <= bus.in_tag;
            rem_q <= '0;
            if (bus.in_op == OP_MUL && MUL_LAT > 1) begin
                state       <= MUL_WAIT;
                cnt         <= CNT_W'(MUL_LAT - 1);
                out_valid_q <= 1'b0;
            end else if (bus.in_op == OP_DIV && bus.in_b != '0) begin
                state       <= DIV_RUN;
                cnt         <= CNT_W'(DATA_W);
                out_valid_q <= 1'b0;
            end else begin
                state        <= OUT;
                out_valid_q  <= 1'b1;
                out_result_q <= imm_result;
                out_tag_q    <= bus.in_tag;
                out_err_q    <= imm_err;
            end
        end else begin
            case (state)
                MUL_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state        <= OUT;
                        out_valid_q  <= 1'b1;
                        out_result_q <= a_q * b_q;
                        out_tag_q    <= tag_q;
                        out_err_q    <= 1'b0;
                    end
                end
                DIV_RUN: begin
                    cnt   <= cnt - 1'b1;
                    a_q   <= div_quo_n;
                    rem_q <= div_rem_n;
                    if (cnt == CNT_W'(1)) begin
                        state        <= OUT;
                        out_valid_q  <= 1'b1;
                        out_result_q <= div_quo_n;
                        out_tag_q    <= tag_q;
                        out_err_q    <= 1'b0;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - directed self-checking bench for mc_alu
module tb_mc_alu;
    localparam int DATA_W  = 32;
    localparam int MUL_LAT = 3;
    localparam int TAG_W   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mc_alu_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    mc_alu #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then count extra edges until out_valid; lat=-1 on timeout.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_b     = 32'h1234_5678;
        bus.in_tag   = 4'hF;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) lat = -1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        checks++;
        if ({bus.out_valid, bus.out_err} !== 2'b00 || bus.out_result !== 32'd0 || bus.out_tag !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b r=%h t=%0d e=%0b exp=0", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_add();
        int lat;
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 4'd3, lat);
        checks++;
        if (lat !== 0 || bus.out_result !== 32'h1 || bus.out_tag !== 4'd3 || bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL add got lat=%0d r=%h t=%0d e=%0b exp lat=0 r=1 t=3 e=0", lat, bus.out_result, bus.out_tag, bus.out_err);
        end
        tick();
    endtask

    task automatic test_mul();
        int lat;
        int guard;
        bool_wait: begin
            guard = 0;
            while (!bus.in_ready && guard < 10) begin tick(); guard++; end
        end
        bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'h1_0000; bus.in_b = 32'h1_0003; bus.in_tag = 4'd7;
        tick();
        bus.in_valid = 1'b1; bus.in_op = 4'd2; bus.in_a = 32'd9; bus.in_b = 32'd9; bus.in_tag = 4'd1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mul_busy_ready got=%0b exp=0", bus.in_ready); end
        lat = 0;
        while (!bus.out_valid && lat < 100) begin tick(); lat++; end
        bus.in_valid = 1'b0;
        checks++;
        if (lat !== MUL_LAT - 1 || bus.out_result !== 32'h0003_0000 || bus.out_tag !== 4'd7 || bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL mul got lat=%0d r=%h t=%0d e=%0b exp lat=%0d r=00030000 t=7 e=0", lat, bus.out_result, bus.out_tag, bus.out_err, MUL_LAT - 1);
        end
        tick();
    endtask

    task automatic test_div();
        int lat;
        do_op(4'd1, 32'd100, 32'd7, 4'd4, lat);
        checks++;
        if (lat !== DATA_W || bus.out_result !== 32'd14 || bus.out_tag !== 4'd4 || bus.out_err !== 1'b0) begin
            failures++;
            $display("FAIL div got lat=%0d r=%0d t=%0d e=%0b exp lat=%0d r=14 t=4 e=0", lat, bus.out_result, bus.out_tag, bus.out_err, DATA_W);
        end
        tick();
        do_op(4'd1, 32'd5, 32'd0, 4'd5, lat);
        checks++;
        if (lat !== 0 || bus.out_result !== 32'hFFFF_FFFF || bus.out_tag !== 4'd5 || bus.out_err !== 1'b1) begin
            failures++;
            $display("FAIL div_zero got lat=%0d r=%h t=%0d e=%0b exp lat=0 r=ffffffff t=5 e=1", lat, bus.out_result, bus.out_tag, bus.out_err);
        end
        tick();
    endtask

    task automatic test_shifts_illegal();
        int lat;
        do_op(4'd4, 32'd1, 32'h23, 4'd6, lat);
        checks++;
        if (lat !== 0 || bus.out_result !== 32'd8 || bus.out_err !== 1'b0) begin
            failures++; $display("FAIL sll got lat=%0d r=%h e=%0b exp lat=0 r=8 e=0", lat, bus.out_result, bus.out_err);
        end
        tick();
        do_op(4'd5, 32'h8000_0000, 32'd31, 4'd8, lat);
        checks++;
        if (lat !== 0 || bus.out_result !== 32'd1 || bus.out_tag !== 4'd8) begin
            failures++; $display("FAIL srl got lat=%0d r=%h t=%0d exp lat=0 r=1 t=8", lat, bus.out_result, bus.out_tag);
        end
        tick();
        do_op(4'd12, 32'd3, 32'd4, 4'd2, lat);
        checks++;
        if (lat !== 0 || bus.out_result !== 32'd0 || bus.out_err !== 1'b1) begin
            failures++; $display("FAIL illegal got lat=%0d r=%h e=%0b exp lat=0 r=0 e=1", lat, bus.out_result, bus.out_err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [3] = '{4'd3, 4'd9, 4'd6};
        logic [31:0] as  [3] = '{32'd10, 32'hF0, 32'd3};
        logic [31:0] bs  [3] = '{32'd3, 32'hFF, 32'd5};
        logic [31:0] exp [3] = '{32'd7, 32'h0F, 32'd1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_op = ops[i]; bus.in_a = as[i]; bus.in_b = bs[i]; bus.in_tag = 4'(i + 1);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== exp[i] || bus.out_tag !== 4'(i + 1)) begin
                failures++;
                $display("FAIL b2b_%0d got v=%0b r=%h t=%0d exp v=1 r=%h t=%0d", i, bus.out_valid, bus.out_result, bus.out_tag, exp[i], i + 1);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got v=%0b exp 0", bus.out_valid); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 4'd2; bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_tag = 4'd5;
        tick();
        bus.in_op = 4'd7; bus.in_a = 32'hC; bus.in_b = 32'hA; bus.in_tag = 4'd6;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 || bus.out_tag !== 4'd5 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_%0d got v=%0b r=%h t=%0d rdy=%0b exp v=1 r=2 t=5 rdy=0", i, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd8 || bus.out_tag !== 4'd6) begin
            failures++; $display("FAIL stall_next got v=%0b r=%h t=%0d exp v=1 r=8 t=6", bus.out_valid, bus.out_result, bus.out_tag);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        int lat;
        bus.in_valid = 1'b1; bus.in_op = 4'd1; bus.in_a = 32'd100; bus.in_b = 32'd7; bus.in_tag = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_mid got v=%0b rdy=%0b exp v=0 rdy=0", bus.out_valid, bus.in_ready);
        end
        tick();
        rst_n = 1'b1;
        repeat (DATA_W + 2) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale got v=%0b exp 0", bus.out_valid); end
        end
        do_op(4'd2, 32'd2, 32'd3, 4'd9, lat);
        checks++;
        if (lat !== 0 || bus.out_result !== 32'd5 || bus.out_tag !== 4'd9 || bus.out_err !== 1'b0) begin
            failures++; $display("FAIL rst_add got lat=%0d r=%h t=%0d e=%0b exp lat=0 r=5 t=9 e=0", lat, bus.out_result, bus.out_tag, bus.out_err);
        end
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_shifts_illegal();
        test_back_to_back();
        test_stall();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised multi-cycle ALU with a valid/ready handshake on both input and output.
- Width and multiply latency are configurable; the divider is iterative.
- Each result carries back a transaction tag and an error flag.
- Sits between the operand-issue logic and the result writeback. Holds one operation in flight.

Parameters:
- DATA_W, 32, operand/result width; must be at least 4.
- MUL_LAT, 3, cycles from accept to out_valid for MUL; must be at least 1.
- TAG_W, 4, width of the transaction tag passed through unchanged.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- in_op  input  4  opcode: 0 MUL, 1 DIV, 2 ADD, 3 SUB, 4 SLL, 5 SRL, 6 SLT, 7 AND, 8 OR, 9 XOR. Codes 10-15 are illegal.
- in_a  input  DATA_W  operand A.
- in_b  input  DATA_W  operand B.
- in_tag  input  TAG_W  request tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  DATA_W  result.
- out_tag  output  TAG_W  tag of the completed operation.
- out_err  output  1  illegal opcode or divide by zero.

Behaviour:
- Reset and clock: clk is the clock; rst_n is the reset, asynchronous, active-low.
- Reset values: state=IDLE, in_ready=0 while rst_n low, out_valid=0, out_result=0, out_tag=0, out_err=0, all internal counters and registers 0.
- Handshakes:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==OUT && out_ready). This allows back-to-back single-cycle ops at one per clock.
- State machine, states IDLE, MUL_WAIT, DIV_RUN, OUT:
  - IDLE, on accept: MUL goes to MUL_WAIT. DIV with in_b!=0 goes to DIV_RUN. Everything else computes and goes to OUT.
  - MUL_WAIT: cycle counter loaded with MUL_LAT-1. Goes to OUT when the counter reaches 0. If MUL_LAT=1, MUL behaves as a single-cycle op.
  - DIV_RUN: restoring division, one quotient bit per cycle, DATA_W iterations, then goes to OUT.
  - OUT: out_valid=1. On transfer, goes to IDLE, or directly dispatches a new accept if in_valid is high. Without a transfer it holds.
- Latency, for an accept at edge N:
  - Single-cycle ops: out_valid at N+1.
  - MUL: out_valid at N+MUL_LAT.
  - DIV: out_valid at N+DATA_W+1.
- Operand capture: in_a, in_b, in_op and in_tag are registered at accept. Later input changes have no effect on the operation in flight.
- Output stability: out_result, out_tag and out_err hold stable while out_valid && !out_ready.
- Arithmetic (all unsigned, modulo 2^DATA_W):
  - MUL returns the low DATA_W bits of the product.
  - DIV returns the quotient; the remainder is discarded.
  - ADD and SUB wrap.
  - SLL is a left shift and SRL is a logical right shift. The shift amount is in_b[$clog2(DATA_W)-1:0]; upper bits are ignored.
  - SLT returns 1 if a<b, else 0.
- Divide by zero: result is all ones, out_err=1, latency 1 (no iteration).
- Illegal opcode: result 0, out_err=1, latency 1.
- out_err is 0 for all legal, non-zero-divisor operations.
- Reset mid-operation: the in-flight operation is discarded, with no output and no stale out_valid after release.

Test Plan:
- ADD a=0xFFFFFFFF, b=2, tag=3 -> next cycle out_valid=1, result=0x00000001, tag=3, err=0.
- MUL a=0x10000, b=0x10003, MUL_LAT=3 -> out_valid exactly 3 cycles after accept, result=0x00030000 (low bits), in_ready=0 meanwhile.
- DIV a=100, b=7 -> result=14 after DATA_W+1 cycles. DIV a=5, b=0 -> result=0xFFFFFFFF, err=1 after 1 cycle.
- Back-to-back SUB/XOR/SLT with out_ready=1 -> one result per cycle, tags in order. Repeat with out_ready held low 4 cycles -> out_* stable, in_ready=0, no loss.
- SLL a=1, b=0x23 (shift 3) -> 8. SRL a=0x80000000, b=31 -> 1. in_op=12 -> result=0, err=1.
- Assert rst_n low mid-DIV (cycle 10) -> out_valid=0 immediately. After release, a new ADD 2+3 returns 5 with the correct tag.
